// File: rtl/reg_bank_dump.sv
// 32-entry register bank with a synchronous write port, two registered read ports and a
// valid/ready debug dump engine. Optional macro WRITE_BYPASS_EN forwards same-cycle writes to reads.
module reg_bank_dump #(
    parameter int DATA_W   = 32,
    parameter int SP_INDEX = 29,
    parameter int SP_INIT  = 227
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [DATA_W-1:0] read_data1_q, read_data1_d;
    logic [DATA_W-1:0] read_data2_q, read_data2_d;
    logic [1:0]        state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic              wr_en;
    logic              beat_done;

    // r0 is never written, so it reads zero without any special read-side handling.
    assign wr_en = reg_write && (write_reg != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_comb begin
        read_data1_d = regs_q[read_reg1];
        read_data2_d = regs_q[read_reg2];
`ifdef WRITE_BYPASS_EN
        if (wr_en && (write_reg == read_reg1)) begin
            read_data1_d = write_data;
        end
        if (wr_en && (write_reg == read_reg2)) begin
            read_data2_d = write_data;
        end
`endif
    end

    assign dump_valid = (state_q == S_SEND) || (state_q == S_LAST);
    assign dump_busy  = (state_q != S_IDLE);
    assign beat_done  = dump_valid && dump_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_SEND;
                    idx_d   = 5'd0;
                end
            end
            S_SEND: begin
                if (beat_done) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd30) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (beat_done) begin
                    state_d = S_IDLE;
                    idx_d   = 5'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_INIT) : '0;
            end
            read_data1_q <= '0;
            read_data2_q <= '0;
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
        end else begin
            regs_q       <= regs_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
        end
    end

    // Dump data is read live from the array so a committed write shows up on a stalled beat.
    assign dump_index = idx_q;
    assign dump_data  = dump_valid ? regs_q[idx_q] : '0;
    assign read_data1 = read_data1_q;
    assign read_data2 = read_data2_q;

endmodule

// File: tb/tb_reg_bank_dump.sv
// Bench for reg_bank_dump: spec-level model checked every cycle plus literal spot checks.
module tb_reg_bank_dump;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = 5'd0;
    logic [31:0] write_data = 32'd0;
    logic [4:0]  read_reg1 = 5'd0;
    logic [4:0]  read_reg2 = 5'd0;
    logic [31:0] read_data1, read_data2;
    logic        dump_start = 1'b0;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        dump_busy;

    int total = 0;
    int bad   = 0;
    bit en_cmp = 1'b0;

    always #5 clk = ~clk;

    reg_bank_dump dut (
        .clk(clk), .reset_n(reset_n),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_data(dump_data), .dump_busy(dump_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: register file as a plain array, the dump as "active + beat number".
    logic [31:0] m_regs [32];
    logic [31:0] m_rd1, m_rd2;
    bit          m_act;
    int          m_beat;

    always @(posedge clk or negedge reset_n) begin : model
        logic [31:0] n1, n2;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_regs[29] = 32'd227;
            m_rd1 = 32'd0;
            m_rd2 = 32'd0;
            m_act = 1'b0;
            m_beat = 0;
        end else begin
            n1 = m_regs[read_reg1];
            n2 = m_regs[read_reg2];
`ifdef WRITE_BYPASS_EN
            if (reg_write && write_reg != 5'd0 && write_reg == read_reg1) n1 = write_data;
            if (reg_write && write_reg != 5'd0 && write_reg == read_reg2) n2 = write_data;
`endif
            m_rd1 = n1;
            m_rd2 = n2;
            if (m_act) begin
                if (dump_ready) begin
                    m_beat++;
                    if (m_beat == 32) begin
                        m_act = 1'b0;
                        m_beat = 0;
                    end
                end
            end else if (dump_start) begin
                m_act = 1'b1;
                m_beat = 0;
            end
            if (reg_write && write_reg != 5'd0) m_regs[write_reg] = write_data;
        end
    end

    logic [4:0]  log_idx [$];
    logic [31:0] log_dat [$];

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("read_data1", read_data1, m_rd1);
            chk("read_data2", read_data2, m_rd2);
            chk("dump_valid", 32'(dump_valid), 32'(m_act));
            chk("dump_busy", 32'(dump_busy), 32'(m_act));
            chk("dump_index", 32'(dump_index), m_act ? 32'(m_beat) : 32'd0);
            chk("dump_data", dump_data, m_act ? m_regs[m_beat] : 32'd0);
            if (reset_n && dump_valid && dump_ready) begin
                log_idx.push_back(dump_index);
                log_dat.push_back(dump_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_order(input string nm);
        chk({nm, "_beats"}, 32'(log_idx.size()), 32'd32);
        for (int i = 0; i < log_idx.size(); i++) begin
            chk({nm, "_order"}, 32'(log_idx[i]), 32'(i));
        end
    endtask

    // Wait (bounded) for dump_busy to drop; returns the number of edges taken.
    task automatic wait_idle(input string nm, output int n);
        n = 0;
        while (dump_busy && n < 200) begin
            cyc();
            n++;
        end
        if (dump_busy) chk({nm, "_timeout"}, 32'(dump_busy), 32'd0);
    endtask

    initial begin
        int n;
        #1 reset_n = 1'b0;
        en_cmp = 1'b1;
        read_reg1 = 5'd29;
        read_reg2 = 5'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc();
        chk("rst_sp", read_data1, 32'd227);
        chk("rst_r0", read_data2, 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);

        // Write to r0 is dropped
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hDEADBEEF;
        cyc();
        reg_write = 1'b0;
        cyc();
        chk("r0_write", read_data2, 32'd0);

        // Same-cycle write and read of r8
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h12345678; read_reg1 = 5'd8;
        cyc();
        reg_write = 1'b0;
`ifdef WRITE_BYPASS_EN
        chk("r8_first", read_data1, 32'h12345678);
`else
        chk("r8_first", read_data1, 32'd0);
`endif
        cyc();
        chk("r8_second", read_data1, 32'h12345678);

        // A few more writes, port 2 reading the target
        for (int i = 1; i < 8; i++) begin
            reg_write = 1'b1; write_reg = 5'(i); write_data = 32'h11111111 * i;
            read_reg2 = 5'(i); read_reg1 = 5'(i - 1);
            cyc();
        end
        reg_write = 1'b0;
        cyc();
        chk("r7_read", read_data2, 32'h77777777);

        // Dump with ready held high; starts while busy and on the last beat are ignored
        log_idx.delete(); log_dat.delete();
        dump_ready = 1'b1; dump_start = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
            dump_start = (n == 10) || (n == 32);
        end while (dump_busy && n < 100);
        dump_start = 1'b0;
        chk("dump1_len", 32'(n), 32'd33);
        check_order("dump1");
        if (log_dat.size() == 32) begin
            chk("dump1_r29", log_dat[29], 32'd227);
            chk("dump1_r8", log_dat[8], 32'h12345678);
            chk("dump1_r0", log_dat[0], 32'd0);
        end
        cyc();
        chk("dump1_idle", 32'(dump_busy), 32'd0);

        // Dump with ready toggling; r31 written while beat 5 is pending
        log_idx.delete(); log_dat.delete();
        read_reg1 = 5'd31;
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        n = 0;
        while (dump_busy && n < 200) begin
            dump_ready = n[0];
            reg_write = (dump_valid && dump_index == 5'd5 && write_reg != 5'd31);
            write_reg = reg_write ? 5'd31 : write_reg;
            write_data = 32'hCAFE0001;
            cyc();
            n++;
        end
        reg_write = 1'b0;
        if (dump_busy) chk("dump2_timeout", 32'(dump_busy), 32'd0);
        check_order("dump2");
        if (log_dat.size() == 32) chk("dump2_r31", log_dat[31], 32'hCAFE0001);
        chk("dump2_read31", read_data1, 32'hCAFE0001);

        // Reset pulse during beat 12
        dump_ready = 1'b1;
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        n = 0;
        while (!(dump_valid && dump_index == 5'd12) && n < 50) begin
            cyc();
            n++;
        end
        chk("beat12_reached", 32'(dump_index), 32'd12);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_busy", 32'(dump_busy), 32'd0);
        chk("abort_rd1", read_data1, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc();
        log_idx.delete(); log_dat.delete();
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        wait_idle("dump3", n);
        check_order("dump3");
        if (log_dat.size() == 32) begin
            chk("dump3_r8", log_dat[8], 32'd0);
            chk("dump3_r29", log_dat[29], 32'd227);
            chk("dump3_r31", log_dat[31], 32'd0);
        end
        cyc();
        en_cmp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
